// File: rtl/io_pmp_seq_checker.sv
// Sequential IO-PMP checker: one shared entry matcher walks entries 0..NR_ENTRIES-1, one per cycle.
// Optional sticky denial log is compiled in with `define IO_PMP_ERR_LOG_EN.
module io_pmp_seq_checker #(
    parameter int unsigned PLEN           = 56,
    parameter int unsigned PMP_LEN        = 54,
    parameter int unsigned NR_ENTRIES     = 16,
    parameter int          PMPGranularity = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [PLEN-1:0]               req_addr_i,
    input  logic [2:0]                    req_type_i,
    input  logic                          req_priv_m_i,
    input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
    input  logic [NR_ENTRIES*8-1:0]       conf_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_allow_o,
    output logic                          rsp_match_o,
    output logic [$clog2(NR_ENTRIES)-1:0] rsp_entry_o,
    output logic                          busy_o
`ifdef IO_PMP_ERR_LOG_EN
    ,
    output logic                          err_valid_o,
    output logic [PLEN-1:0]               err_addr_o,
    output logic [2:0]                    err_type_o,
    input  logic                          err_clear_i
`endif
);

    localparam int unsigned IDXW = $clog2(NR_ENTRIES);

    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    // With coarse granularity the low NAPOT bits read back as ones.
    localparam logic [PMP_LEN-1:0] G_ONES =
        (PMPGranularity > 2) ? PMP_LEN'((64'd1 << (PMPGranularity - 2)) - 64'd1) : '0;
    localparam bit NA4_OK = (PMPGranularity <= 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESP
    } state_e;

    state_e             r_state;
    logic [IDXW-1:0]    r_idx;
    logic [PLEN-1:0]    r_addr;
    logic [2:0]         r_type;
    logic               r_priv_m;
    logic               r_allow;
    logic               r_match;
    logic [IDXW-1:0]    r_entry;

    logic [PMP_LEN-1:0] w_addr_arr [NR_ENTRIES];
    logic [7:0]         w_cfg_arr  [NR_ENTRIES];

    for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_unpack
        assign w_addr_arr[g] = conf_addr_i[g*PMP_LEN +: PMP_LEN];
        assign w_cfg_arr[g]  = conf_i[g*8 +: 8];
    end

    logic [PMP_LEN-1:0] w_word;
    logic [PMP_LEN-1:0] w_cur_addr;
    logic [PMP_LEN-1:0] w_prev_addr;
    logic [7:0]         w_cur_cfg;
    logic [PMP_LEN-1:0] w_napot_cfg;
    logic [PMP_LEN-1:0] w_napot_mask;
    logic               w_tor_hit;
    logic               w_na4_hit;
    logic               w_napot_hit;
    logic               w_hit;
    logic               w_perm_ok;
    logic               w_allow_hit;
    logic               w_last;

    assign w_word      = PMP_LEN'(r_addr >> 2);
    assign w_cur_addr  = w_addr_arr[r_idx];
    assign w_prev_addr = (r_idx == '0) ? '0 : w_addr_arr[r_idx - 1'b1];
    assign w_cur_cfg   = w_cfg_arr[r_idx];

    // x ^ (x+1) sets the trailing-ones run plus the first zero: exactly the in-region word bits.
    assign w_napot_cfg  = w_cur_addr | G_ONES;
    assign w_napot_mask = w_napot_cfg ^ (w_napot_cfg + 1'b1);

    assign w_tor_hit   = (w_word >= w_prev_addr) && (w_word < w_cur_addr);
    assign w_na4_hit   = NA4_OK && (w_word == w_cur_addr);
    assign w_napot_hit = ((w_word ^ w_napot_cfg) & ~w_napot_mask) == '0;

    always_comb begin
        w_hit = 1'b0;
        case (w_cur_cfg[4:3])
            A_OFF:   w_hit = 1'b0;
            A_TOR:   w_hit = w_tor_hit;
            A_NA4:   w_hit = w_na4_hit;
            A_NAPOT: w_hit = w_napot_hit;
            default: w_hit = 1'b0;
        endcase
    end

    assign w_perm_ok   = (r_type & w_cur_cfg[2:0]) == r_type;
    assign w_allow_hit = (r_priv_m && !w_cur_cfg[7]) || w_perm_ok;
    assign w_last      = (r_idx == IDXW'(NR_ENTRIES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_addr   <= '0;
            r_type   <= '0;
            r_priv_m <= 1'b0;
            r_allow  <= 1'b0;
            r_match  <= 1'b0;
            r_entry  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_addr   <= req_addr_i;
                        r_type   <= req_type_i;
                        r_priv_m <= req_priv_m_i;
                        r_idx    <= '0;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        r_allow <= w_allow_hit;
                        r_match <= 1'b1;
                        r_entry <= r_idx;
                        r_state <= ST_RESP;
                    end else if (w_last) begin
                        // No entry matched: machine mode defaults open, others closed.
                        r_allow <= r_priv_m;
                        r_match <= 1'b0;
                        r_entry <= '0;
                        r_state <= ST_RESP;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_allow_o = r_allow;
    assign rsp_match_o = r_match;
    assign rsp_entry_o = r_entry;

`ifdef IO_PMP_ERR_LOG_EN
    logic            r_err_valid;
    logic [PLEN-1:0] r_err_addr;
    logic [2:0]      r_err_type;
    logic            w_deny_hs;

    assign w_deny_hs = (r_state == ST_RESP) && rsp_ready_i && !r_allow;

    // First denial is sticky; clear takes priority over a simultaneous capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_type  <= '0;
        end else if (err_clear_i) begin
            r_err_valid <= 1'b0;
        end else if (w_deny_hs && !r_err_valid) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr;
            r_err_type  <= r_type;
        end
    end

    assign err_valid_o = r_err_valid;
    assign err_addr_o  = r_err_addr;
    assign err_type_o  = r_err_type;
`endif

    // Reserved cfg bits and the byte offset only feed the optional log.
    logic w_unused;
    assign w_unused = ^{conf_i, r_addr};

endmodule

// File: tb/tb_io_pmp_seq_checker.sv
// Bench for io_pmp_seq_checker: directed vector table, hand sequences, and random
// requests checked against a range-based reference model.
module tb_io_pmp_seq_checker;

    localparam int PLEN    = 56;
    localparam int PMP_LEN = 54;
    localparam int NR      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [PLEN-1:0]   req_addr = '0;
    logic [2:0]        req_type = '0;
    logic              req_priv = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_allow;
    logic              rsp_match;
    logic [3:0]        rsp_entry;
    logic              busy;
    logic              err_clear = 1'b0;
`ifdef IO_PMP_ERR_LOG_EN
    logic              err_valid;
    logic [PLEN-1:0]   err_addr;
    logic [2:0]        err_type;
`endif

    logic [PMP_LEN-1:0]    cfg_addr [NR];
    logic [7:0]            cfg      [NR];
    logic [NR*PMP_LEN-1:0] conf_addr;
    logic [NR*8-1:0]       conf;

    always #5 clk = ~clk;

    always_comb begin
        conf_addr = '0;
        conf      = '0;
        for (int i = 0; i < NR; i++) begin
            conf_addr[i*PMP_LEN +: PMP_LEN] = cfg_addr[i];
            conf[i*8 +: 8]                  = cfg[i];
        end
    end

    io_pmp_seq_checker #(
        .PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR), .PMPGranularity(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_type_i(req_type), .req_priv_m_i(req_priv),
        .conf_addr_i(conf_addr), .conf_i(conf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_allow_o(rsp_allow), .rsp_match_o(rsp_match), .rsp_entry_o(rsp_entry),
        .busy_o(busy)
`ifdef IO_PMP_ERR_LOG_EN
        ,
        .err_valid_o(err_valid), .err_addr_o(err_addr), .err_type_o(err_type),
        .err_clear_i(err_clear)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: each entry is turned into a byte range [lo, hi) and tested directly.
    function automatic void model(input logic [PLEN-1:0] a, input logic [2:0] t, input logic p,
                                  output logic ea, output logic em, output logic [3:0] ee,
                                  output int el);
        longint unsigned addr;
        longint unsigned lo;
        longint unsigned hi;
        longint unsigned sz;
        int  ones;
        logic hit;
        addr = 64'(a);
        ea = p; em = 1'b0; ee = 4'd0; el = NR;
        for (int i = 0; i < NR; i++) begin
            hit = 1'b0;
            case (cfg[i][4:3])
                2'd1: begin
                    lo  = (i == 0) ? 64'd0 : (64'(cfg_addr[i-1]) << 2);
                    hi  = 64'(cfg_addr[i]) << 2;
                    hit = (addr >= lo) && (addr < hi);
                end
                2'd2: begin
                    lo  = 64'(cfg_addr[i]) << 2;
                    hit = (addr >= lo) && (addr < lo + 64'd4);
                end
                2'd3: begin
                    ones = 0;
                    while (ones < PMP_LEN && cfg_addr[i][ones]) ones++;
                    sz  = 64'd1 << (ones + 3);
                    lo  = (64'(cfg_addr[i]) << 2) & ~(sz - 64'd1);
                    hit = (addr >= lo) && (addr < lo + sz);
                end
                default: hit = 1'b0;
            endcase
            if (hit) begin
                em = 1'b1;
                ee = 4'(i);
                el = i + 1;
                ea = (p && !cfg[i][7]) ? 1'b1 : ((t & cfg[i][2:0]) == t);
                return;
            end
        end
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < NR; i++) begin
            cfg_addr[i] = '0;
            cfg[i]      = '0;
        end
    endtask

    task automatic setup(input int s);
        clear_cfg();
        case (s)
            1: begin cfg_addr[3] = 54'h1FF; cfg[3] = 8'h1B; end
            2: begin cfg_addr[0] = 54'h400; cfg[0] = 8'h09; end
            3: begin cfg_addr[0] = 54'h400; cfg[0] = 8'h89; end
            4: begin
                cfg_addr[1] = 54'h9FF; cfg[1] = 8'h18;
                cfg_addr[5] = 54'hBFF; cfg[5] = 8'h1F;
            end
            5: begin cfg_addr[2] = 54'h400; cfg[2] = 8'h11; end
            default: ;
        endcase
    endtask

    task automatic rand_cfg();
        int unsigned k;
        int unsigned base;
        for (int i = 0; i < NR; i++) begin
            cfg[i] = {1'($urandom_range(0, 1)), 2'b00, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            case (cfg[i][4:3])
                2'd3: begin
                    k    = $urandom_range(0, 10);
                    base = $urandom_range(0, 32'h4000) & ~((32'd1 << (k + 1)) - 1);
                    cfg_addr[i] = 54'(base | ((32'd1 << k) - 1));
                end
                default: cfg_addr[i] = 54'($urandom_range(0, 32'h4000));
            endcase
        end
    endtask

    // Issues one request from idle, waits for the response, optionally holds it hold cycles.
    task automatic run_req(input logic [PLEN-1:0] a, input logic [2:0] t, input logic p,
                           input int hold, input logic clr,
                           output logic allow, output logic match, output logic [3:0] entry,
                           output int lat);
        int n;
        check("ready_in_idle", req_ready, 1);
        req_addr = a; req_type = t; req_priv = p; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        allow = 1'b0; match = 1'b0; entry = 4'd0; lat = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        allow = rsp_allow; match = rsp_match; entry = rsp_entry;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_ready", req_ready, 0);
            check("hold_allow", rsp_allow, allow);
            check("hold_match", rsp_match, match);
            check("hold_entry", rsp_entry, entry);
        end
        rsp_ready = 1'b1; err_clear = clr;
        @(posedge clk); #1;
        rsp_ready = 1'b0; err_clear = 1'b0;
    endtask

    typedef struct {
        int              scen;
        logic [PLEN-1:0] addr;
        logic [2:0]      t;
        logic            p;
        logic            ea;
        logic            em;
        logic [3:0]      ee;
        int              el;
    } vec_t;

    vec_t vt [19];

    initial begin
        logic        a_allow, a_match, e_allow, e_match;
        logic [3:0]  a_entry, e_entry;
        int          a_lat, e_lat;
        logic        seen;
        logic [PLEN-1:0] ra;
        logic [2:0]      rt;
        logic            rp;

        vt[0]  = '{1, 56'h800,  3'b010, 1'b0, 1'b1, 1'b1, 4'd3, 4};
        vt[1]  = '{1, 56'h1000, 3'b001, 1'b0, 1'b0, 1'b0, 4'd0, 16};
        vt[2]  = '{1, 56'hFFC,  3'b100, 1'b0, 1'b0, 1'b1, 4'd3, 4};
        vt[3]  = '{1, 56'h0,    3'b011, 1'b0, 1'b1, 1'b1, 4'd3, 4};
        vt[4]  = '{1, 56'h10,   3'b110, 1'b0, 1'b0, 1'b1, 4'd3, 4};
        vt[5]  = '{2, 56'h10,   3'b010, 1'b0, 1'b0, 1'b1, 4'd0, 1};
        vt[6]  = '{2, 56'h10,   3'b010, 1'b1, 1'b1, 1'b1, 4'd0, 1};
        vt[7]  = '{2, 56'h0,    3'b001, 1'b0, 1'b1, 1'b1, 4'd0, 1};
        vt[8]  = '{2, 56'hFFC,  3'b001, 1'b0, 1'b1, 1'b1, 4'd0, 1};
        vt[9]  = '{2, 56'h1000, 3'b001, 1'b0, 1'b0, 1'b0, 4'd0, 16};
        vt[10] = '{3, 56'h10,   3'b010, 1'b1, 1'b0, 1'b1, 4'd0, 1};
        vt[11] = '{3, 56'h10,   3'b001, 1'b1, 1'b1, 1'b1, 4'd0, 1};
        vt[12] = '{0, 56'h0,    3'b001, 1'b0, 1'b0, 1'b0, 4'd0, 16};
        vt[13] = '{0, 56'h0,    3'b001, 1'b1, 1'b1, 1'b0, 4'd0, 16};
        vt[14] = '{4, 56'h2000, 3'b001, 1'b0, 1'b0, 1'b1, 4'd1, 2};
        vt[15] = '{4, 56'h3800, 3'b001, 1'b0, 1'b1, 1'b1, 4'd5, 6};
        vt[16] = '{5, 56'h1000, 3'b001, 1'b0, 1'b1, 1'b1, 4'd2, 3};
        vt[17] = '{5, 56'h1004, 3'b001, 1'b0, 1'b0, 1'b0, 4'd0, 16};
        vt[18] = '{4, 56'h2000, 3'b001, 1'b1, 1'b1, 1'b1, 4'd1, 2};

        clear_cfg();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_allow", rsp_allow, 0);
        check("rst_match", rsp_match, 0);
        check("rst_entry", rsp_entry, 0);
`ifdef IO_PMP_ERR_LOG_EN
        check("rst_err_valid", err_valid, 0);
        check("rst_err_addr", err_addr, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", req_ready, 1);
        check("idle_busy", busy, 0);

        for (int v = 0; v < 19; v++) begin
            setup(vt[v].scen);
            run_req(vt[v].addr, vt[v].t, vt[v].p, 0, 1'b0, a_allow, a_match, a_entry, a_lat);
            check($sformatf("vec%0d_allow", v), a_allow, vt[v].ea);
            check($sformatf("vec%0d_match", v), a_match, vt[v].em);
            check($sformatf("vec%0d_entry", v), a_entry, vt[v].ee);
            check($sformatf("vec%0d_lat", v), a_lat, vt[v].el);
        end

        // Response held off for five cycles must stay put with the input side closed.
        setup(4);
        run_req(56'h2000, 3'b001, 1'b0, 5, 1'b0, a_allow, a_match, a_entry, a_lat);
        check("hold_final_allow", a_allow, 0);
        check("hold_final_entry", a_entry, 1);
        check("after_hold_ready", req_ready, 1);

        // Reset in the middle of a scan aborts without a response.
        setup(0);
        req_addr = 56'h40; req_type = 3'b001; req_priv = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scan_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_ready", req_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", seen, 0);

`ifdef IO_PMP_ERR_LOG_EN
        setup(0);
        run_req(56'h3000, 3'b001, 1'b0, 0, 1'b0, a_allow, a_match, a_entry, a_lat);
        check("err_first_valid", err_valid, 1);
        run_req(56'h4000, 3'b010, 1'b0, 0, 1'b0, a_allow, a_match, a_entry, a_lat);
        check("err_sticky_valid", err_valid, 1);
        check("err_sticky_addr", err_addr, 56'h3000);
        check("err_sticky_type", err_type, 3'b001);
        run_req(56'h5000, 3'b001, 1'b0, 0, 1'b1, a_allow, a_match, a_entry, a_lat);
        check("err_clear_wins", err_valid, 0);
        run_req(56'h6000, 3'b100, 1'b0, 0, 1'b0, a_allow, a_match, a_entry, a_lat);
        check("err_recapture_valid", err_valid, 1);
        check("err_recapture_addr", err_addr, 56'h6000);
`endif

        for (int c = 0; c < 4; c++) begin
            rand_cfg();
            for (int r = 0; r < 12; r++) begin
                ra = 56'($urandom_range(0, 32'h10FFF));
                rt = 3'($urandom_range(1, 7));
                rp = 1'($urandom_range(0, 1));
                model(ra, rt, rp, e_allow, e_match, e_entry, e_lat);
                run_req(ra, rt, rp, 0, 1'b0, a_allow, a_match, a_entry, a_lat);
                check("rnd_allow", a_allow, e_allow);
                check("rnd_match", a_match, e_match);
                check("rnd_entry", a_entry, e_entry);
                check("rnd_lat", a_lat, e_lat);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_pmp_seq_checker.md
Name: io_pmp_seq_checker

Overview:
- Area-optimised, sequential PMP checker for the IO-PMP.
- Time-multiplexes one pmp_entry matcher across NR_ENTRIES configured regions, evaluating one entry per cycle in priority order (entry 0 highest).
- Takes one request at a time through a valid/ready handshake and returns allow/deny plus the matching entry index.
- Sits between the AXI-side request capture and the IO-PMP register file, which supplies the pmpaddr/pmpcfg arrays.

Parameters:
PLEN, 56, physical address width
PMP_LEN, 54, pmpaddr register width
NR_ENTRIES, 16, number of PMP entries (2..64)
PMPGranularity, 2, granularity G passed to the matcher

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high together with req_valid_i
req_addr_i  in  PLEN  access address
req_type_i  in  3  access type, one-hot: bit0 R, bit1 W, bit2 X
req_priv_m_i  in  1  1 = machine-mode access
conf_addr_i  in  NR_ENTRIES*PMP_LEN  pmpaddr array, entry i at [i*PMP_LEN +: PMP_LEN]
conf_i  in  NR_ENTRIES*8  pmpcfg bytes: [0] R, [1] W, [2] X, [4:3] A (OFF/TOR/NA4/NAPOT), [7] L
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_allow_o  out  1  1 = access permitted
rsp_match_o  out  1  1 = an entry matched
rsp_entry_o  out  $clog2(NR_ENTRIES)  index of the matching entry (0 if none)
busy_o  out  1  high while a request is in flight (SCAN or RESP)

Behaviour:
- Reset:
  - State IDLE.
  - rsp_valid_o, rsp_allow_o, rsp_match_o, rsp_entry_o and busy_o are 0.
  - Latched request registers and the index counter are 0.
  - Reset asserted mid-scan or mid-response aborts immediately; no response is issued.
- FSM: IDLE -> SCAN -> RESP -> IDLE.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i && req_ready_o: latch addr, type and priv; set idx = 0; go to SCAN.
- SCAN:
  - req_ready_o = 0.
  - The matcher receives addr, conf_addr[idx], prev = (idx == 0 ? 0 : conf_addr[idx-1]) and A of cfg[idx].
  - Entry hit means A != OFF and the matcher reports a match.
  - On a hit:
    - rsp_match = 1, rsp_entry = idx.
    - allow = 1 if priv_m and L = 0.
    - Otherwise allow = ((type & cfg[idx][2:0]) == type).
    - Go to RESP.
  - On a miss with idx == NR_ENTRIES-1: rsp_match = 0, rsp_entry = 0, allow = priv_m (M-mode default allow, other modes default deny). Go to RESP.
  - Otherwise idx++.
- RESP:
  - rsp_valid_o = 1; all rsp_* outputs are registered and stable until the handshake.
  - On rsp_ready_i: go to IDLE. rsp_valid_o drops on the next edge.
  - req_ready_o stays 0 until back in IDLE, so there is no same-cycle accept on response completion.
- Latency:
  - Hit on entry k: rsp_valid_o is high k+1 edges after the accept edge.
  - No hit: rsp_valid_o is high NR_ENTRIES edges after the accept edge.
  - Minimum request period is k+3 cycles.
- Config handling:
  - conf_addr_i and conf_i are read live during SCAN.
  - The register file must not change them while busy_o = 1. A change during that window gives an undefined decision but no protocol violation.
- Lock bit: L = 1 applies the permission check to M-mode accesses too.
- req_type_i with more than one bit set: each set bit must be permitted (AND semantics).
- Boundaries:
  - TOR on entry 0 uses a lower bound of 0.
  - NA4 with PMPGranularity > 2 never matches, so scanning continues.
  - The idx counter must not wrap past NR_ENTRIES-1.

Optional Feature:
- Macro: IO_PMP_ERR_LOG_EN.
- When defined, add the following ports:
  - err_valid_o (1)
  - err_addr_o (PLEN)
  - err_type_o (3)
  - err_clear_i (1)
- On every response handshake with allow = 0 while err_valid_o = 0: capture addr and type, and set err_valid_o (sticky).
- Later denials do not overwrite the captured record.
- err_clear_i clears err_valid_o on the next edge. If a denial handshake occurs in the same cycle as err_clear_i, clear wins.
- Reset clears all err_* state.
- When the macro is undefined, these ports and their registers are absent.

Test Plan:
- Reset then idle → all outputs 0, req_ready_o = 1; reset asserted in SCAN → IDLE, no rsp_valid_o.
- NR_ENTRIES = 16, entry 3 NAPOT addr 0x1FF (4 KiB at 0x0), cfg R|W; U-mode write to 0x800 → allow = 1, match = 1, entry = 3, rsp_valid 4 edges after accept.
- Entry 0 TOR pmpaddr 0x400 (top 0x1000), cfg R; U-mode write to 0x10 → allow = 0, entry = 0. M-mode write with L = 0 → allow = 1. M-mode write with L = 1 → allow = 0.
- All entries OFF: U-mode read → allow = 0, match = 0 after 16 edges; M-mode read → allow = 1.
- Overlap: entries 1 and 5 both cover 0x2000, entry 1 with no permissions → deny from entry 1. Hold rsp_ready_i low 5 cycles → outputs stable, req_ready_o = 0 throughout.
- IO_PMP_ERR_LOG_EN: deny at 0x3000 then deny at 0x4000 → err_addr_o = 0x3000; err_clear_i together with a third deny → err_valid_o = 0.
